// File: rtl/dmem_wbuf.sv
// Data memory behind a posted-store write buffer on a single-port RAM (async read, sync write).
// Define DMEM_WBUF_STORE_FWD_EN to let loads read pending stores instead of stalling on them.
module dmem_wbuf #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_BITS  = 8,
    parameter int WB_DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       MemWriteM,
    input  logic                       MemReadM,
    input  logic [31:0]                AddrM,
    input  logic [DATA_WIDTH-1:0]      WriteDataM,
    output logic [DATA_WIDTH-1:0]      ReadDataM,
    output logic                       BusyM,
    output logic [$clog2(WB_DEPTH):0]  WbCount
);
    localparam int PTR_W = $clog2(WB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] ram    [2**ADDR_BITS];
    logic [ADDR_BITS-1:0]  wbIdx  [WB_DEPTH];
    logic [DATA_WIDTH-1:0] wbData [WB_DEPTH];
    logic [PTR_W-1:0]      ageSlot [WB_DEPTH];
    logic [WB_DEPTH-1:0]   ageHit;

    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [CNT_W-1:0]      count;
    logic [ADDR_BITS-1:0]  wordIdx;
    logic                  fwdHit;
    logic [DATA_WIDTH-1:0] fwdData;
    logic                  isLoad;
    logic                  full;
    logic                  loadBusy;
    logic                  portFree;
    logic                  doEnq;
    logic                  doDeq;
    logic                  unusedAddr;

    assign wordIdx    = AddrM[ADDR_BITS+1:2];
    assign unusedAddr = ^{AddrM[31:ADDR_BITS+2], AddrM[1:0]};

    // Slot k is the k-th oldest entry; only the first 'count' slots hold live stores.
    for (genvar k = 0; k < WB_DEPTH; k++) begin : gAge
        assign ageSlot[k] = head + PTR_W'(k);
        assign ageHit[k]  = (CNT_W'(k) < count) && (wbIdx[ageSlot[k]] == wordIdx);
    end

    // Scanning oldest to youngest lets the youngest matching store win.
    always_comb begin
        fwdHit  = 1'b0;
        fwdData = '0;
        for (int k = 0; k < WB_DEPTH; k++) begin
            if (ageHit[k]) begin
                fwdHit  = 1'b1;
                fwdData = wbData[ageSlot[k]];
            end
        end
    end

`ifdef DMEM_WBUF_STORE_FWD_EN
    assign loadBusy = 1'b0;
`else
    assign loadBusy = fwdHit;
`endif

    // A simultaneous read and write is a store; a stalled access leaves the RAM port to the drain.
    assign isLoad    = MemReadM & ~MemWriteM;
    assign full      = (count == CNT_W'(WB_DEPTH));
    assign BusyM     = MemWriteM ? full : (isLoad & loadBusy);
    assign portFree  = ~MemReadM | BusyM;
    assign doEnq     = MemWriteM & ~full;
    assign doDeq     = (count != '0) & portFree;
    assign ReadDataM = (isLoad & ~BusyM) ? (fwdHit ? fwdData : ram[wordIdx]) : '0;
    assign WbCount   = count;

    // Reset empties the buffer instantly, dropping any stores that never reached the RAM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (doEnq) tail <= tail + PTR_W'(1);
            if (doDeq) head <= head + PTR_W'(1);
            case ({doEnq, doDeq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (doEnq) begin
            wbIdx[tail]  <= wordIdx;
            wbData[tail] <= WriteDataM;
        end
        if (doDeq) ram[wbIdx[head]] <= wbData[head];
    end
endmodule

// File: tb/tb_dmem_wbuf.sv
// Bench for dmem_wbuf: queue-based reference model checked every cycle, directed scenarios
// with literal expectations, then randomized traffic with occasional asynchronous resets.
module tb_dmem_wbuf;
    localparam int DW    = 32;
    localparam int AB    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef DMEM_WBUF_STORE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          MemWriteM;
    logic          MemReadM;
    logic [31:0]   AddrM;
    logic [DW-1:0] WriteDataM;
    logic [DW-1:0] ReadDataM;
    logic          BusyM;
    logic [CW-1:0] WbCount;

    dmem_wbuf #(.DATA_WIDTH(DW), .ADDR_BITS(AB), .WB_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .MemWriteM(MemWriteM), .MemReadM(MemReadM),
        .AddrM(AddrM), .WriteDataM(WriteDataM), .ReadDataM(ReadDataM),
        .BusyM(BusyM), .WbCount(WbCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AB-1:0] idx;
        logic [DW-1:0] data;
    } entry_t;

    entry_t        wbq[$];
    logic [DW-1:0] ramModel [2**AB];
    bit            ramKnown [2**AB];
    int            checks   = 0;
    int            failures = 0;
    logic [DW-1:0] lastRead;
    logic          lastBusy;

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected outputs follow from the pending-store list and the RAM image, then the
    // model advances to the state the next rising edge must produce.
    task automatic checkOutput();
        logic [AB-1:0] idx;
        logic [DW-1:0] fwd;
        logic [DW-1:0] expRead;
        bit isLoad, hit, full, expBusy, readKnown;
        idx    = AddrM[AB+1:2];
        isLoad = MemReadM && !MemWriteM;
        full   = (wbq.size() == DEPTH);
        hit    = 1'b0;
        fwd    = '0;
        foreach (wbq[i]) if (wbq[i].idx == idx) begin hit = 1'b1; fwd = wbq[i].data; end
        if (MemWriteM)   expBusy = full;
        else if (isLoad) expBusy = FWD ? 1'b0 : hit;
        else             expBusy = 1'b0;
        readKnown = 1'b1;
        expRead   = '0;
        if (isLoad && !expBusy) begin
            if (hit) expRead = fwd;
            else begin expRead = ramModel[idx]; readKnown = ramKnown[idx]; end
        end
        lastRead = ReadDataM;
        lastBusy = BusyM;
        compare("busy", BusyM, expBusy);
        compare("wbCount", WbCount, wbq.size());
        if (readKnown) compare("readData", ReadDataM, expRead);
        if (wbq.size() > 0 && (!MemReadM || expBusy)) begin
            ramModel[wbq[0].idx] = wbq[0].data;
            ramKnown[wbq[0].idx] = 1'b1;
            void'(wbq.pop_front());
        end
        if (MemWriteM && !full) wbq.push_back('{idx, WriteDataM});
    endtask

    // Called one time unit after a rising edge; returns one time unit after the next.
    task automatic applyStimulus(input logic w, input logic r, input logic [31:0] addr,
                                 input logic [DW-1:0] data);
        MemWriteM  = w;
        MemReadM   = r;
        AddrM      = addr;
        WriteDataM = data;
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
    endtask

    task automatic midReset();
        MemWriteM = 1'b1;
        MemReadM  = 1'b0;
        reset     = 1'b1;
        #2;
        compare("resetCount", WbCount, 0);
        compare("resetBusy", BusyM, 1'b0);
        wbq.delete();
        #1 reset = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 32'h0, '0);
    endtask

    initial begin
        int guard;
        logic [31:0] addr;
        reset = 1'b1; MemWriteM = 1'b0; MemReadM = 1'b0; AddrM = '0; WriteDataM = '0;
        #2;
        compare("initCount", WbCount, 0);
        compare("initBusy", BusyM, 1'b0);
        #11 reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, i * 4, 32'h100 + i);
        idle(2);

        // Stores paired with a read hold the port, so the buffer accumulates.
        applyStimulus(1'b1, 1'b1, 32'h10, 32'hA);  compare("fill1", WbCount, 1);
        applyStimulus(1'b1, 1'b1, 32'h14, 32'hB);  compare("fill2", WbCount, 2);
        applyStimulus(1'b1, 1'b1, 32'h18, 32'hC);  compare("fill3", WbCount, 3);
        idle(1); compare("drain2", WbCount, 2);
        idle(1); compare("drain1", WbCount, 1);
        idle(1); compare("drain0", WbCount, 0);
        applyStimulus(1'b0, 1'b1, 32'h10, '0); compare("loadA", lastRead, 32'hA);
        applyStimulus(1'b0, 1'b1, 32'h14, '0); compare("loadB", lastRead, 32'hB);
        applyStimulus(1'b0, 1'b1, 32'h18, '0); compare("loadC", lastRead, 32'hC);

        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 32'h20 + i * 4, 32'h200 + i);
        compare("fullCount", WbCount, 4);
        applyStimulus(1'b1, 1'b1, 32'h30, 32'h555);
        compare("fullBusy", lastBusy, 1'b1);
        compare("fullDrained", WbCount, 3);
        applyStimulus(1'b1, 1'b1, 32'h30, 32'h555);
        compare("fifthAccepted", lastBusy, 1'b0);
        compare("refilled", WbCount, 4);
        idle(5);

        applyStimulus(1'b1, 1'b1, 32'h40, 32'h11);
        applyStimulus(1'b1, 1'b1, 32'h40, 32'h22);
        applyStimulus(1'b0, 1'b1, 32'h40, '0);
        guard = 0;
        while (lastBusy && guard < 8) begin
            applyStimulus(1'b0, 1'b1, 32'h40, '0);
            guard++;
        end
        compare("hitStallBounded", guard < 8, 1'b1);
        compare("hitData", lastRead, 32'h22);
        idle(3);

        applyStimulus(1'b1, 1'b1, 32'h200, 32'h77);
        applyStimulus(1'b1, 1'b1, 32'h204, 32'h88);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 32'h0, '0);
        compare("loadBlocksDrain", WbCount, 2);
        idle(1); compare("unblock1", WbCount, 1);
        idle(1); compare("unblock0", WbCount, 0);

        applyStimulus(1'b1, 1'b1, 32'h10, 32'hDEAD0);
        applyStimulus(1'b1, 1'b1, 32'h20, 32'hDEAD1);
        applyStimulus(1'b1, 1'b1, 32'h30, 32'hDEAD2);
        compare("preResetCount", WbCount, 3);
        midReset();
        applyStimulus(1'b0, 1'b1, 32'h10, '0);
        compare("discarded", lastRead, 32'hA);

        applyStimulus(1'b1, 1'b1, 32'h80, 32'h5);
        compare("rwReadZero", lastRead, 32'h0);
        compare("rwEnqueued", WbCount, 1);
        idle(1);
        applyStimulus(1'b0, 1'b1, 32'h80, '0);
        compare("rwLater", lastRead, 32'h5);

        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(199) == 0) midReset();
            else begin
                addr = ($urandom & 32'hFFFF_FC03) | (32'($urandom_range(15)) << 2);
                applyStimulus(1'($urandom_range(1)), 1'($urandom_range(1)), addr, $urandom);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
